// File: rtl/sync_cnt_pkg.sv
// Shared constants and types for the T-flip-flop down counter.
// Holds the default counter width and its all-ones maximum value.
package sync_cnt_pkg;

    localparam int unsigned SDC_DEFAULT_WIDTH = 4;

    localparam logic [SDC_DEFAULT_WIDTH-1:0] SDC_MAX_VAL = '1;

    // Next-state operation selected each cycle, in priority order load > dec > hold.
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_DEC  = 2'd1,
        CNT_LOAD = 2'd2
    } cnt_op_e;

endpackage

// File: rtl/T_ff.sv
// Single toggle flip-flop with asynchronous active-low reset.
// Q inverts on a rising clk edge whenever T is high.
module T_ff (
    input  logic clk,
    input  logic rstn,
    input  logic T,
    output logic Q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end

endmodule

// File: rtl/sync_down_counter.sv
// WIDTH-bit down counter built from T flip-flops, with parallel load and borrow pulse.
// Define SYNC_DOWN_COUNTER_SATURATE_EN to hold at zero on underflow instead of wrapping.
module sync_down_counter
    import sync_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = SDC_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             borrow
);

    cnt_op_e          w_op;
    logic             w_underflow;
    logic [WIDTH-1:0] w_dec_t;
    logic [WIDTH-1:0] w_t;
    logic             r_borrow;

    always_comb begin
        w_op = CNT_HOLD;
        if (load) begin
            w_op = CNT_LOAD;
        end else if (en) begin
            w_op = CNT_DEC;
        end
    end

    assign w_underflow = (w_op == CNT_DEC) && (Q == '0);

    // A bit toggles on decrement only when every lower bit is zero (it must borrow).
    assign w_dec_t[0] = 1'b1;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_dec
        assign w_dec_t[gi] = ~|Q[gi-1:0];
    end

    always_comb begin
        w_t = '0;
        unique case (w_op)
            CNT_LOAD: w_t = Q ^ load_val;
            CNT_DEC: begin
`ifdef SYNC_DOWN_COUNTER_SATURATE_EN
                w_t = w_underflow ? '0 : w_dec_t;
`else
                w_t = w_dec_t;
`endif
            end
            default: w_t = '0;
        endcase
    end

    for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
        T_ff u_tff (
            .clk  (clk),
            .rstn (rstn),
            .T    (w_t[gb]),
            .Q    (Q[gb])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_borrow <= 1'b0;
        end else begin
            r_borrow <= w_underflow;
        end
    end

    assign borrow = r_borrow;
    assign zero   = (Q == '0);

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter (WIDTH=4) against a modulo-arithmetic model.
// Honours SYNC_DOWN_COUNTER_SATURATE_EN in the model so either build can be checked.
module tb_sync_down_counter;
    import sync_cnt_pkg::*;

    localparam int unsigned W   = SDC_DEFAULT_WIDTH;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] Q;
    logic         zero;
    logic         borrow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned m_q;
    int unsigned m_borrow;

    sync_down_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .Q        (Q),
        .zero     (zero),
        .borrow   (borrow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".Q"}, int'(Q), m_q);
        check_val({tag, ".zero"}, int'(zero), (m_q == 0) ? 1 : 0);
        check_val({tag, ".borrow"}, int'(borrow), m_borrow);
    endtask

    // Reference behaviour for one rising edge with reset released.
    task automatic model_edge(input bit e, input bit l, input int unsigned v);
        if (l) begin
            m_q      = v % MOD;
            m_borrow = 0;
        end else if (e) begin
            if (m_q == 0) begin
                m_borrow = 1;
`ifdef SYNC_DOWN_COUNTER_SATURATE_EN
                m_q = 0;
`else
                m_q = MOD - 1;
`endif
            end else begin
                m_q      = m_q - 1;
                m_borrow = 0;
            end
        end else begin
            m_borrow = 0;
        end
    endtask

    task automatic step(input bit e, input bit l, input int unsigned v, input string tag);
        en       = e;
        load     = l;
        load_val = W'(v);
        @(posedge clk);
        model_edge(e, l, v);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges, held across one edge, then released.
    task automatic async_reset(input string tag);
        #2;
        rstn     = 1'b0;
        m_q      = 0;
        m_borrow = 0;
        #1;
        check_val({tag, ".rst_Q"}, int'(Q), 0);
        check_val({tag, ".rst_zero"}, int'(zero), 1);
        check_val({tag, ".rst_borrow"}, int'(borrow), 0);
        en   = 1'b1;
        load = 1'b1;
        load_val = W'(7);
        @(posedge clk);
        #1;
        check_val({tag, ".rst_edge_Q"}, int'(Q), 0);
        check_val({tag, ".rst_edge_borrow"}, int'(borrow), 0);
        #2;
        rstn = 1'b1;
        en   = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn     = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
        m_q      = 0;
        m_borrow = 0;
        #1;
        check_all("reset_init");
        #11;
        rstn = 1'b1;

        // Load takes priority over enable and yields no borrow.
        step(1'b1, 1'b1, 32'hA, "load_A");

        // Count down through zero.
        step(1'b0, 1'b1, 3, "load_3");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, "count");
        step(1'b0, 1'b0, 0, "count_after");

        // Hold.
        step(1'b0, 1'b1, 5, "load_5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, "hold");

        // Underflow path from 1 (saturating build: back-to-back borrow pulses).
        step(1'b0, 1'b1, 1, "load_1");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, "underflow");

        // Load at zero with en=1 must not underflow.
        step(1'b0, 1'b1, 0, "load_0");
        step(1'b1, 1'b1, 7, "load_over_en");

        // Reset mid-count at Q=9.
        step(1'b0, 1'b1, 9, "load_9");
        async_reset("mid9");
        step(1'b1, 1'b0, 0, "post_rst");

        // Reset while borrow is high clears it immediately.
        step(1'b0, 1'b1, 0, "load_0b");
        step(1'b1, 1'b0, 0, "borrow_hi");
        async_reset("borrow_rst");

        // Randomized traffic, biased toward small loads to exercise underflow.
        for (int i = 0; i < 200; i++) begin
            bit          re;
            bit          rl;
            int unsigned rv;
            re = ($urandom_range(0, 3) != 0);
            rl = ($urandom_range(0, 7) == 0);
            rv = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1) : $urandom_range(0, MOD - 1);
            step(re, rl, rv, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
